// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: start control, instruction-memory read channel,
// instruction/branch exchange with the decoder, and status.
// INSTR_COUNT_EN adds the retired-instruction counter output.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 10
);
    logic                start_i;
    logic                imem_req_o;
    logic [PC_WIDTH-1:0] imem_addr_o;
    logic [7:0]          imem_rdata_i;
    logic                imem_ack_i;
    logic [7:0]          instruction_o;
    logic                instr_valid_o;
    logic                branchf_i;
    logic                branchb_i;
    logic [7:0]          offset_i;
    logic                done_i;
    logic                halted_o;
    logic [PC_WIDTH-1:0] pc_o;
`ifdef INSTR_COUNT_EN
    logic [31:0]         retired_count_o;
`endif

    // Fetch unit side.
    modport master (
        input  start_i, imem_rdata_i, imem_ack_i, branchf_i, branchb_i,
               offset_i, done_i,
        output imem_req_o, imem_addr_o, instruction_o, instr_valid_o,
               halted_o, pc_o
`ifdef INSTR_COUNT_EN
      , output retired_count_o
`endif
    );

    // Environment side: memory, decoder and controller.
    modport slave (
        output start_i, imem_rdata_i, imem_ack_i, branchf_i, branchb_i,
               offset_i, done_i,
        input  imem_req_o, imem_addr_o, instruction_o, instr_valid_o,
               halted_o, pc_o
`ifdef INSTR_COUNT_EN
      , input  retired_count_o
`endif
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction sequencer: owns the PC, fetches one byte per instruction over
// a req/ack handshake, presents it for a single execute cycle and picks the
// next PC from the decoder's done/branchf/branchb response.
// Optional macro INSTR_COUNT_EN adds a 32-bit retired-instruction counter.
module instr_fetch #(
    parameter int PC_WIDTH = 10,
    parameter int START_PC = 0
) (
    input  logic          clock_i,
    input  logic          reset_i,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [PC_WIDTH-1:0] START = PC_WIDTH'(START_PC);

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] off_ext;
    logic [7:0]          instruction;
    logic                instr_valid;
    logic                halted;
`ifdef INSTR_COUNT_EN
    logic [31:0]         retired_count;
`endif

    // Offset is unsigned: zero-extended, or truncated for narrow PCs.
    assign off_ext = PC_WIDTH'(bus.offset_i);

    // Sequencer FSM; PC arithmetic wraps naturally at PC_WIDTH bits.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            pc            <= START;
            instruction   <= 8'h00;
            instr_valid   <= 1'b0;
            halted        <= 1'b0;
`ifdef INSTR_COUNT_EN
            retired_count <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state <= FETCH;
                        pc    <= START;
`ifdef INSTR_COUNT_EN
                        retired_count <= 32'd0;
`endif
                    end
                end
                FETCH: begin
                    if (bus.imem_ack_i) begin
                        instruction <= bus.imem_rdata_i;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    instr_valid <= 1'b0;
`ifdef INSTR_COUNT_EN
                    retired_count <= retired_count + 32'd1;
`endif
                    if (bus.done_i) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= FETCH;
                        if (bus.branchf_i)
                            pc <= pc + off_ext;
                        else if (bus.branchb_i)
                            pc <= pc - off_ext;
                        else
                            pc <= pc + 1'b1;
                    end
                end
                HALT: begin
                    if (bus.start_i) begin
                        halted <= 1'b0;
                        pc     <= START;
                        state  <= FETCH;
`ifdef INSTR_COUNT_EN
                        retired_count <= 32'd0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request follows state directly so an async reset drops it at once.
    assign bus.imem_req_o    = (state == FETCH);
    assign bus.imem_addr_o   = pc;
    assign bus.pc_o          = pc;
    assign bus.instruction_o = instruction;
    assign bus.instr_valid_o = instr_valid;
    assign bus.halted_o      = halted;
`ifdef INSTR_COUNT_EN
    assign bus.retired_count_o = retired_count;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed steps plus randomized programs, checked
// against a simple PC/counter model (modular arithmetic on integers).
module tb_instr_fetch;
    localparam int PCW = 10;
    localparam int MOD = 1 << PCW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.PC_WIDTH(PCW)) bus();
    instr_fetch #(.PC_WIDTH(PCW), .START_PC(0)) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         exp_pc = 0;
    int         exp_count = 0;
    logic [7:0] last_instr = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(int pc, bit bf, bit bb, int off);
        if (bf) return (pc + off) % MOD;
        if (bb) return (pc - off + MOD) % MOD;
        return (pc + 1) % MOD;
    endfunction

    task automatic quiet();
        bus.start_i      = 1'b0;
        bus.imem_ack_i   = 1'b0;
        bus.imem_rdata_i = 8'h00;
        bus.branchf_i    = 1'b0;
        bus.branchb_i    = 1'b0;
        bus.done_i       = 1'b0;
        bus.offset_i     = 8'h00;
    endtask

    task automatic chk_count();
`ifdef INSTR_COUNT_EN
        chk("retired_count", bus.retired_count_o, 32'(exp_count));
`endif
    endtask

    task automatic do_start();
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        exp_pc    = 0;
        exp_count = 0;
        chk("start_halted", 32'(bus.halted_o), 32'd0);
        chk_count();
    endtask

    // Entered in FETCH; ends in EXEC after the ack edge.
    task automatic do_fetch(input int wt, input logic [7:0] b);
        chk("fetch_req", 32'(bus.imem_req_o), 32'd1);
        chk("fetch_addr", 32'(bus.imem_addr_o), 32'(exp_pc));
        chk("fetch_valid", 32'(bus.instr_valid_o), 32'd0);
        for (int i = 0; i < wt; i++) begin
            bus.start_i   = 1'($urandom);
            bus.branchf_i = 1'($urandom);
            bus.branchb_i = 1'($urandom);
            bus.done_i    = 1'($urandom);
            bus.offset_i  = 8'($urandom);
            @(negedge clk);
            chk("wait_req", 32'(bus.imem_req_o), 32'd1);
            chk("wait_addr", 32'(bus.imem_addr_o), 32'(exp_pc));
            chk("wait_valid", 32'(bus.instr_valid_o), 32'd0);
        end
        quiet();
        bus.imem_ack_i   = 1'b1;
        bus.imem_rdata_i = b;
        @(negedge clk);
        bus.imem_ack_i   = 1'b0;
        bus.imem_rdata_i = 8'($urandom);
        last_instr = b;
        chk("exec_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("exec_instr", 32'(bus.instruction_o), 32'(b));
        chk("exec_pc", 32'(bus.pc_o), 32'(exp_pc));
        chk("exec_req", 32'(bus.imem_req_o), 32'd0);
    endtask

    // Entered in EXEC; stray start/ack during EXEC must be ignored.
    task automatic do_exec(input bit bf, input bit bb, input bit dn, input logic [7:0] off);
        bus.branchf_i  = bf;
        bus.branchb_i  = bb;
        bus.done_i     = dn;
        bus.offset_i   = off;
        bus.start_i    = 1'($urandom);
        bus.imem_ack_i = 1'($urandom);
        @(negedge clk);
        quiet();
        exp_count++;
        if (dn) begin
            chk("halt_flag", 32'(bus.halted_o), 32'd1);
            chk("halt_req", 32'(bus.imem_req_o), 32'd0);
            chk("halt_pc", 32'(bus.pc_o), 32'(exp_pc));
        end else begin
            exp_pc = model_next(exp_pc, bf, bb, int'(off));
            chk("next_req", 32'(bus.imem_req_o), 32'd1);
            chk("next_addr", 32'(bus.imem_addr_o), 32'(exp_pc));
            chk("next_valid", 32'(bus.instr_valid_o), 32'd0);
            chk("instr_hold", 32'(bus.instruction_o), 32'(last_instr));
            chk("not_halted", 32'(bus.halted_o), 32'd0);
        end
        chk("exec_valid_drop", 32'(bus.instr_valid_o), 32'd0);
        chk_count();
    endtask

    // Idle cycles in HALT with stray ack/done that must not matter.
    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.imem_ack_i = 1'($urandom);
            bus.done_i     = 1'($urandom);
            @(negedge clk);
            chk("halt_hold", 32'(bus.halted_o), 32'd1);
            chk("halt_noreq", 32'(bus.imem_req_o), 32'd0);
        end
        quiet();
    endtask

    initial begin
        int r;
        bit bf, bb, dn;
        quiet();
        rst = 1'b1;
        #7;
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_pc", 32'(bus.pc_o), 32'd0);
        chk("rst_instr", 32'(bus.instruction_o), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("rst_halted", 32'(bus.halted_o), 32'd0);
        chk_count();
        @(negedge clk);
        rst = 1'b0;
        // IDLE ignores ack
        bus.imem_ack_i   = 1'b1;
        bus.imem_rdata_i = 8'h99;
        repeat (2) @(negedge clk);
        quiet();
        chk("idle_req", 32'(bus.imem_req_o), 32'd0);
        chk("idle_instr", 32'(bus.instruction_o), 32'd0);

        // Directed: zero-wait fetch, delayed ack, branch arithmetic, wrap
        do_start();
        do_fetch(0, 8'h41);  do_exec(0, 0, 0, 8'd0);   // -> 1
        do_fetch(3, 8'h12);  do_exec(1, 0, 0, 8'd9);   // -> 10
        do_fetch(0, 8'h20);  do_exec(1, 0, 0, 8'd5);   // -> 15
        do_fetch(1, 8'h21);  do_exec(0, 1, 0, 8'd5);   // -> 10
        do_fetch(0, 8'h22);  do_exec(0, 1, 0, 8'd12);  // -> 1022
        do_fetch(2, 8'h23);  do_exec(1, 0, 0, 8'd12);  // -> 10
        do_fetch(0, 8'h24);  do_exec(1, 1, 0, 8'd5);   // -> 15
        do_fetch(0, 8'h25);  do_exec(0, 1, 0, 8'd16);  // -> 1023
        do_fetch(0, 8'h26);  do_exec(0, 0, 0, 8'd0);   // -> 0
        do_fetch(0, 8'h27);  do_exec(1, 0, 0, 8'd0);   // self-loop at 0
        do_fetch(0, 8'h28);  do_exec(0, 1, 0, 8'd0);   // self-loop at 0

        // Randomized programs
        for (int n = 0; n < 60; n++) begin
            do_fetch(int'($urandom_range(0, 3)), 8'($urandom));
            r  = int'($urandom_range(0, 9));
            dn = (r == 0);
            bf = (r >= 1 && r <= 5);
            bb = (r >= 5 && r <= 7);
            do_exec(bf, bb, dn, 8'($urandom));
            if (dn) begin
                halt_cycles(int'($urandom_range(0, 2)));
                do_start();
            end
        end

        // Async reset mid-fetch, then a late ack
        do_fetch(0, 8'h30);  do_exec(1, 0, 0, 8'd37);
        #1 rst = 1'b1;
        #1;
        chk("midrst_req", 32'(bus.imem_req_o), 32'd0);
        chk("midrst_pc", 32'(bus.pc_o), 32'd0);
        chk("midrst_instr", 32'(bus.instruction_o), 32'd0);
        bus.imem_ack_i   = 1'b1;
        bus.imem_rdata_i = 8'hEE;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        quiet();
        last_instr = 8'h00;
        exp_pc     = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_req", 32'(bus.imem_req_o), 32'd0);
            chk("postrst_valid", 32'(bus.instr_valid_o), 32'd0);
            chk("postrst_instr", 32'(bus.instruction_o), 32'd0);
        end

        // Halt at pc 7 after 8 instructions, then restart
        do_start();
        for (int i = 0; i < 7; i++) begin
            do_fetch(0, 8'($urandom));
            do_exec(0, 0, 0, 8'd0);
        end
        do_fetch(0, 8'hFF);
        chk("halt_at_pc7", 32'(bus.pc_o), 32'd7);
        do_exec(0, 0, 1, 8'd0);
`ifdef INSTR_COUNT_EN
        chk("count_before_restart", bus.retired_count_o, 32'd8);
`endif
        halt_cycles(20);
        do_start();
        do_fetch(0, 8'h41);
        do_exec(0, 0, 0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
